regex_pc_scheduler: RTL and testbench

- Thread scheduler that sits around regex_cpu_pipelined.
- It feeds the CPU its input_pc and current_character, and consumes the output_pc stream the CPU produces.
- Each produced PC is routed into a current-character queue or a next-character queue. Characters are fetched from an input stream, and the queues swap each time a character is exhausted.
- It reports match completion and accept/reject to the top-level controller.

---
 rtl/regex_pc_scheduler_pkg.sv | 16 +
 rtl/regex_pc_scheduler_if.sv | 44 ++++
 rtl/regex_pc_fifo.sv | 57 +++++
 rtl/regex_pc_scheduler.sv | 168 ++++++++++++++++
 tb/tb_regex_pc_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regex_pc_scheduler_pkg.sv
// Shared types for the regex thread scheduler: FSM states and default queue sizing.
// No logic; pure declarations.
// Imported by the scheduler top and its interface users.
package regex_pc_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RUN,
        FLUSH,
        DONE
    } sched_state_t;

    localparam int DEFAULT_FIFO_WIDTH_POWER_OF_2 = 3;

endpackage

// File: rtl/regex_pc_scheduler_if.sv
// Bundle of the controller, character-stream and CPU handshakes around the scheduler.
// master = scheduler side, slave = controller/CPU/stream side.
// Pure wiring; no latency or backpressure of its own.
interface regex_pc_scheduler_if #(
    parameter int PC_WIDTH        = 8,
    parameter int CHARACTER_WIDTH = 8
);
    logic                       start_valid;
    logic [PC_WIDTH-1:0]        start_pc;
    logic                       start_ready;
    logic                       in_char_valid;
    logic [CHARACTER_WIDTH-1:0] in_char;
    logic                       in_char_last;
    logic                       in_char_ready;
    logic [CHARACTER_WIDTH-1:0] current_character;
    logic                       cpu_input_pc_valid;
    logic [PC_WIDTH-1:0]        cpu_input_pc;
    logic                       cpu_input_pc_ready;
    logic                       cpu_output_pc_valid;
    logic [PC_WIDTH-1:0]        cpu_output_pc;
    logic                       cpu_output_pc_is_directed_to_current;
    logic                       cpu_output_pc_ready;
    logic                       cpu_accepts;
    logic                       cpu_running;
    logic                       done;
    logic                       accepted;

    modport master (
        input  start_valid, start_pc, in_char_valid, in_char, in_char_last,
               cpu_input_pc_ready, cpu_output_pc_valid, cpu_output_pc,
               cpu_output_pc_is_directed_to_current, cpu_accepts, cpu_running,
        output start_ready, in_char_ready, current_character, cpu_input_pc_valid,
               cpu_input_pc, cpu_output_pc_ready, done, accepted
    );

    modport slave (
        output start_valid, start_pc, in_char_valid, in_char, in_char_last,
               cpu_input_pc_ready, cpu_output_pc_valid, cpu_output_pc,
               cpu_output_pc_is_directed_to_current, cpu_accepts, cpu_running,
        input  start_ready, in_char_ready, current_character, cpu_input_pc_valid,
               cpu_input_pc, cpu_output_pc_ready, done, accepted
    );

endinterface

// File: rtl/regex_pc_fifo.sv
// Synchronous PC queue, 2^DEPTH_POW2 entries, with a synchronous clear.
// Latency: pushed entry visible at head the cycle after the push; head is combinational.
// Backpressure: exposes full/empty; a push on full is taken only alongside a pop.
module regex_pc_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_POW2 = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int                  DEPTH    = 1 << DEPTH_POW2;
    localparam logic [DEPTH_POW2:0] FULL_CNT = (DEPTH_POW2 + 1)'(DEPTH);
    localparam logic [DEPTH_POW2:0] CNT_ONE  = (DEPTH_POW2 + 1)'(1);
    localparam logic [DEPTH_POW2-1:0] PTR_ONE = DEPTH_POW2'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_POW2-1:0] rd_ptr;
    logic [DEPTH_POW2-1:0] wr_ptr;
    logic [DEPTH_POW2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/regex_pc_scheduler.sv
// Thread scheduler around the regex CPU: feeds PCs per character, routes produced PCs to cur/nxt queues.
// Latency: start->FETCH 1 cycle; char latch->first PC offer 1 cycle; queue swap->FETCH 1 cycle.
// Backpressure: produced PCs stall while either queue is full; FLUSH sinks every produced PC.
module regex_pc_scheduler
    import regex_pc_scheduler_pkg::*;
#(
    parameter int PC_WIDTH              = 8,
    parameter int CHARACTER_WIDTH       = 8,
    parameter int FIFO_WIDTH_POWER_OF_2 = DEFAULT_FIFO_WIDTH_POWER_OF_2
) (
    input logic                   clk,
    input logic                   rst,
    regex_pc_scheduler_if.master  bus
);

    sched_state_t               state, state_nxt;
    logic                       cur_sel, cur_sel_nxt;
    logic                       last_seen;
    logic                       accepted_q;
    logic                       in_hs_q;
    logic [CHARACTER_WIDTH-1:0] cur_char_q;

    logic [PC_WIDTH-1:0] head_a, head_b, cur_head;
    logic                full_a, full_b, empty_a, empty_b;
    logic                cur_full, cur_empty, nxt_full, nxt_empty;

    logic                start_ready_w, in_char_ready_w, in_pc_valid_w, out_pc_ready_w;
    logic                start_hs, char_hs, in_hs, out_hs, quiescent;

    logic                push_cur, push_nxt, pop_cur, clear_q, acc_load, acc_val;
    logic [PC_WIDTH-1:0] push_cur_data;

    assign cur_head  = cur_sel ? head_b  : head_a;
    assign cur_full  = cur_sel ? full_b  : full_a;
    assign cur_empty = cur_sel ? empty_b : empty_a;
    assign nxt_full  = cur_sel ? full_a  : full_b;
    assign nxt_empty = cur_sel ? empty_a : empty_b;

    assign start_ready_w   = (state == IDLE) && !rst;
    assign in_char_ready_w = (state == FETCH) && bus.in_char_valid;
    assign in_pc_valid_w   = (state == RUN) && !cur_empty;
    assign out_pc_ready_w  = ((state == RUN) && !cur_full && !nxt_full) || (state == FLUSH);

    assign start_hs = bus.start_valid && start_ready_w;
    assign char_hs  = in_char_ready_w;
    assign in_hs    = in_pc_valid_w && bus.cpu_input_pc_ready;
    assign out_hs   = bus.cpu_output_pc_valid && out_pc_ready_w;

    // A PC handed over last cycle may not yet show up in cpu_running.
    assign quiescent = cur_empty && !bus.cpu_running && !bus.cpu_output_pc_valid
                       && !in_hs && !in_hs_q;

    always_comb begin
        state_nxt     = state;
        cur_sel_nxt   = cur_sel;
        push_cur      = 1'b0;
        push_nxt      = 1'b0;
        push_cur_data = bus.cpu_output_pc;
        pop_cur       = 1'b0;
        clear_q       = 1'b0;
        acc_load      = 1'b0;
        acc_val       = 1'b0;
        case (state)
            IDLE: begin
                if (start_hs) begin
                    push_cur      = 1'b1;
                    push_cur_data = bus.start_pc;
                    state_nxt     = FETCH;
                end
            end
            FETCH: begin
                if (char_hs) state_nxt = RUN;
            end
            RUN: begin
                pop_cur = in_hs;
                if (out_hs) begin
                    push_cur = bus.cpu_output_pc_is_directed_to_current;
                    push_nxt = !bus.cpu_output_pc_is_directed_to_current;
                end
                if (bus.cpu_accepts) begin
                    state_nxt = FLUSH;
                end else if (quiescent) begin
                    if (nxt_empty || last_seen) begin
                        state_nxt = DONE;
                        clear_q   = 1'b1;
                        acc_load  = 1'b1;
                    end else begin
                        cur_sel_nxt = !cur_sel;
                        state_nxt   = FETCH;
                    end
                end
            end
            FLUSH: begin
                if (!bus.cpu_running && !bus.cpu_output_pc_valid) begin
                    state_nxt = DONE;
                    clear_q   = 1'b1;
                    acc_load  = 1'b1;
                    acc_val   = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_sel    <= 1'b0;
            last_seen  <= 1'b0;
            accepted_q <= 1'b0;
            in_hs_q    <= 1'b0;
            cur_char_q <= '0;
        end else begin
            state   <= state_nxt;
            cur_sel <= cur_sel_nxt;
            in_hs_q <= in_hs;
            if (char_hs) begin
                cur_char_q <= bus.in_char;
                last_seen  <= bus.in_char_last;
            end
            if (start_hs)      accepted_q <= 1'b0;
            else if (acc_load) accepted_q <= acc_val;
        end
    end

    regex_pc_fifo #(
        .WIDTH      (PC_WIDTH),
        .DEPTH_POW2 (FIFO_WIDTH_POWER_OF_2)
    ) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_q),
        .push      (cur_sel ? push_nxt : push_cur),
        .push_data (cur_sel ? bus.cpu_output_pc : push_cur_data),
        .pop       (!cur_sel && pop_cur),
        .head      (head_a),
        .full      (full_a),
        .empty     (empty_a)
    );

    regex_pc_fifo #(
        .WIDTH      (PC_WIDTH),
        .DEPTH_POW2 (FIFO_WIDTH_POWER_OF_2)
    ) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_q),
        .push      (cur_sel ? push_cur : push_nxt),
        .push_data (cur_sel ? push_cur_data : bus.cpu_output_pc),
        .pop       (cur_sel && pop_cur),
        .head      (head_b),
        .full      (full_b),
        .empty     (empty_b)
    );

    assign bus.start_ready         = start_ready_w;
    assign bus.in_char_ready       = in_char_ready_w;
    assign bus.current_character   = cur_char_q;
    assign bus.cpu_input_pc_valid  = in_pc_valid_w;
    assign bus.cpu_input_pc        = in_pc_valid_w ? cur_head : '0;
    assign bus.cpu_output_pc_ready = out_pc_ready_w;
    assign bus.done                = (state == DONE);
    assign bus.accepted            = accepted_q;

endmodule

// File: tb/tb_regex_pc_scheduler.sv
// Directed bench for regex_pc_scheduler with a small CPU / character-stream model.
// All DUT observations are taken 1 time unit after the falling edge.
module tb_regex_pc_scheduler;
    import regex_pc_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regex_pc_scheduler_if bus ();
    regex_pc_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // CPU response table: input PC -> list of produced PCs with direction flags.
    logic [7:0] rsp_pc  [256][9];
    logic       rsp_dir [256][9];
    int         rsp_n   [256];
    logic       acc_en;
    logic [7:0] acc_pc;

    logic [7:0] chars[$];
    logic       lasts[$];
    logic [7:0] pend_pc[$];
    logic       pend_dir[$];
    logic [7:0] issued_pc[$];
    logic [7:0] issued_ch[$];

    logic       start_req;
    logic [7:0] start_pc_v;
    logic       accept_now, acc_seen;
    logic       p_start_hs, p_char_hs, p_in_hs, p_out_hs;
    logic [7:0] p_in_pc, p_in_ch;
    int         char_pulses, out_pushes, stall_cycles, done_cnt, valid_after_acc;
    logic       done_acc;

    task automatic clear_model();
        for (int i = 0; i < 256; i++) rsp_n[i] = 0;
        acc_en = 1'b0; acc_pc = 8'h00;
        chars.delete(); lasts.delete(); pend_pc.delete(); pend_dir.delete();
        issued_pc.delete(); issued_ch.delete();
        start_req = 1'b0; start_pc_v = 8'h00; accept_now = 1'b0; acc_seen = 1'b0;
        p_start_hs = 1'b0; p_char_hs = 1'b0; p_in_hs = 1'b0; p_out_hs = 1'b0;
        p_in_pc = 8'h00; p_in_ch = 8'h00;
        char_pulses = 0; out_pushes = 0; stall_cycles = 0; done_cnt = 0;
        valid_after_acc = 0; done_acc = 1'b0;
    endtask

    task automatic cycle();
        @(negedge clk);
        accept_now = 1'b0;
        if (p_start_hs) start_req = 1'b0;
        if (p_char_hs) begin
            char_pulses++;
            void'(chars.pop_front()); void'(lasts.pop_front());
        end
        if (p_out_hs) begin
            out_pushes++;
            void'(pend_pc.pop_front()); void'(pend_dir.pop_front());
        end
        if (p_in_hs) begin
            issued_pc.push_back(p_in_pc);
            issued_ch.push_back(p_in_ch);
            for (int i = 0; i < rsp_n[p_in_pc]; i++) begin
                pend_pc.push_back(rsp_pc[p_in_pc][i]);
                pend_dir.push_back(rsp_dir[p_in_pc][i]);
            end
            if (acc_en && p_in_pc == acc_pc) begin
                accept_now = 1'b1;
                acc_seen   = 1'b1;
            end
        end
        bus.start_valid         = start_req;
        bus.start_pc            = start_pc_v;
        bus.in_char_valid       = (chars.size() > 0);
        bus.in_char             = (chars.size() > 0) ? chars[0] : 8'h00;
        bus.in_char_last        = (lasts.size() > 0) ? lasts[0] : 1'b0;
        bus.cpu_input_pc_ready  = 1'b1;
        bus.cpu_output_pc_valid = (pend_pc.size() > 0);
        bus.cpu_output_pc       = (pend_pc.size() > 0) ? pend_pc[0] : 8'h00;
        bus.cpu_output_pc_is_directed_to_current = (pend_dir.size() > 0) ? pend_dir[0] : 1'b0;
        bus.cpu_running         = (pend_pc.size() > 0);
        bus.cpu_accepts         = accept_now;
        #1;
        p_start_hs = bus.start_valid && bus.start_ready;
        p_char_hs  = bus.in_char_valid && bus.in_char_ready;
        p_in_hs    = bus.cpu_input_pc_valid && bus.cpu_input_pc_ready;
        p_out_hs   = bus.cpu_output_pc_valid && bus.cpu_output_pc_ready;
        p_in_pc    = bus.cpu_input_pc;
        p_in_ch    = bus.current_character;
        if (bus.cpu_output_pc_valid && !bus.cpu_output_pc_ready) stall_cycles++;
        if (acc_seen && !accept_now && bus.cpu_input_pc_valid) valid_after_acc++;
        if (bus.done) begin
            done_cnt++;
            done_acc = bus.accepted;
        end
    endtask

    task automatic add_char(input logic [7:0] c, input logic last);
        chars.push_back(c); lasts.push_back(last);
    endtask

    task automatic add_rsp(input logic [7:0] src, input logic [7:0] pc, input logic dir);
        rsp_pc[src][rsp_n[src]]  = pc;
        rsp_dir[src][rsp_n[src]] = dir;
        rsp_n[src]++;
    endtask

    task automatic run_to_done(input logic [7:0] pc, input int budget);
        start_pc_v = pc;
        start_req  = 1'b1;
        for (int i = 0; i < budget && done_cnt == 0; i++) cycle();
        n_checks++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
        for (int i = 0; i < 3; i++) cycle();
    endtask

    task automatic test_reset();
        clear_model();
        rst = 1'b1;
        cycle(); cycle();
        n_checks++;
        if ({bus.start_ready, bus.in_char_ready, bus.cpu_input_pc_valid, bus.cpu_output_pc_ready,
             bus.done, bus.accepted} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000", {bus.start_ready, bus.in_char_ready,
                     bus.cpu_input_pc_valid, bus.cpu_output_pc_ready, bus.done, bus.accepted});
        end
        n_checks++;
        if (bus.cpu_input_pc !== 8'h00 || bus.current_character !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: pc=%h ch=%h want 00/00", bus.cpu_input_pc, bus.current_character);
        end
        rst = 1'b0;
        cycle();
        n_checks++;
        if (bus.start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle_ready: got %b want 1", bus.start_ready);
        end
    endtask

    task automatic test_no_match();
        clear_model();
        add_char(8'h61, 1'b0); add_char(8'h62, 1'b1);
        run_to_done(8'h05, 40);
        n_checks++;
        if (issued_pc.size() != 1 || issued_pc[0] !== 8'h05 || issued_ch[0] !== 8'h61) begin
            n_fail++;
            $display("FAIL nomatch_issue: n=%0d pc=%h ch=%h want 1/05/61", issued_pc.size(),
                     issued_pc.size() ? issued_pc[0] : 8'hxx, issued_ch.size() ? issued_ch[0] : 8'hxx);
        end
        n_checks++;
        if (done_cnt != 1 || done_acc !== 1'b0) begin
            n_fail++;
            $display("FAIL nomatch_done: done=%0d acc=%b want 1/0", done_cnt, done_acc);
        end
        n_checks++;
        if (char_pulses != 1) begin
            n_fail++;
            $display("FAIL nomatch_char_pulses: got %0d want 1", char_pulses);
        end
    endtask

    task automatic test_accept_next();
        clear_model();
        add_char(8'h61, 1'b0); add_char(8'h62, 1'b1);
        add_rsp(8'h05, 8'h06, 1'b0);
        acc_en = 1'b1; acc_pc = 8'h06;
        run_to_done(8'h05, 60);
        n_checks++;
        if (issued_pc.size() != 2 || issued_pc[0] !== 8'h05 || issued_ch[0] !== 8'h61
            || issued_pc[1] !== 8'h06 || issued_ch[1] !== 8'h62) begin
            n_fail++;
            $display("FAIL accept_seq: n=%0d want 05/61 then 06/62", issued_pc.size());
        end
        n_checks++;
        if (done_cnt != 1 || done_acc !== 1'b1 || bus.accepted !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_done: done=%0d acc=%b held=%b want 1/1/1", done_cnt, done_acc, bus.accepted);
        end
        n_checks++;
        if (dut.u_fifo_a.empty !== 1'b1 || dut.u_fifo_b.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_queues_empty: a=%b b=%b want 1/1", dut.u_fifo_a.empty, dut.u_fifo_b.empty);
        end
    endtask

    task automatic test_same_char();
        clear_model();
        add_char(8'h61, 1'b1);
        add_rsp(8'h05, 8'h10, 1'b1); add_rsp(8'h05, 8'h11, 1'b1);
        run_to_done(8'h05, 60);
        n_checks++;
        if (issued_pc.size() != 3 || issued_pc[0] !== 8'h05 || issued_pc[1] !== 8'h10
            || issued_pc[2] !== 8'h11) begin
            n_fail++;
            $display("FAIL samechar_order: n=%0d want 05,10,11", issued_pc.size());
        end
        n_checks++;
        if (issued_ch.size() != 3 || issued_ch[1] !== 8'h61 || issued_ch[2] !== 8'h61) begin
            n_fail++;
            $display("FAIL samechar_char: n=%0d want all 61", issued_ch.size());
        end
        n_checks++;
        if (done_acc !== 1'b0) begin
            n_fail++;
            $display("FAIL samechar_acc: got %b want 0", done_acc);
        end
    endtask

    task automatic test_nxt_full();
        int  pushes_at_stall;
        bit  withdrawn;
        bit  ok;
        clear_model();
        add_char(8'h61, 1'b0); add_char(8'h62, 1'b1);
        for (int i = 0; i < 9; i++) add_rsp(8'h05, 8'(8'h20 + i), 1'b0);
        pushes_at_stall = -1;
        withdrawn = 1'b0;
        start_pc_v = 8'h05; start_req = 1'b1;
        for (int i = 0; i < 120 && done_cnt == 0; i++) begin
            cycle();
            // The 9th PC can never be taken while nxt is full, so the model retracts it.
            if (!withdrawn && stall_cycles >= 3 && pend_pc.size() == 1) begin
                pushes_at_stall = out_pushes;
                pend_pc.delete(); pend_dir.delete();
                withdrawn = 1'b1;
            end
        end
        for (int i = 0; i < 3; i++) cycle();
        n_checks++;
        if (pushes_at_stall != 8) begin
            n_fail++;
            $display("FAIL full_stall_pushes: got %0d want 8", pushes_at_stall);
        end
        ok = (issued_pc.size() == 9);
        for (int i = 1; i < 9 && ok; i++)
            if (issued_pc[i] !== 8'(8'h20 + i - 1) || issued_ch[i] !== 8'h62) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL full_drain_order: n=%0d want 9 with 20..27 under 62", issued_pc.size());
        end
        n_checks++;
        if (done_cnt != 1 || done_acc !== 1'b0) begin
            n_fail++;
            $display("FAIL full_done: done=%0d acc=%b want 1/0", done_cnt, done_acc);
        end
    endtask

    task automatic test_flush();
        clear_model();
        add_char(8'h61, 1'b1);
        add_rsp(8'h05, 8'h30, 1'b1); add_rsp(8'h05, 8'h31, 1'b1);
        acc_en = 1'b1; acc_pc = 8'h05;
        run_to_done(8'h05, 60);
        n_checks++;
        if (issued_pc.size() != 1 || valid_after_acc != 0) begin
            n_fail++;
            $display("FAIL flush_no_issue: n=%0d valid_after=%0d want 1/0", issued_pc.size(), valid_after_acc);
        end
        n_checks++;
        if (out_pushes != 2 || pend_pc.size() != 0) begin
            n_fail++;
            $display("FAIL flush_drain: taken=%0d left=%0d want 2/0", out_pushes, pend_pc.size());
        end
        n_checks++;
        if (done_acc !== 1'b1 || dut.u_fifo_a.empty !== 1'b1 || dut.u_fifo_b.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_result: acc=%b a=%b b=%b want 1/1/1", done_acc,
                     dut.u_fifo_a.empty, dut.u_fifo_b.empty);
        end
    endtask

    task automatic test_reset_mid_run();
        clear_model();
        add_char(8'h61, 1'b0); add_char(8'h62, 1'b1);
        add_rsp(8'h05, 8'h40, 1'b0); add_rsp(8'h05, 8'h41, 1'b0); add_rsp(8'h05, 8'h42, 1'b0);
        start_pc_v = 8'h05; start_req = 1'b1;
        for (int i = 0; i < 40 && out_pushes < 3; i++) cycle();
        n_checks++;
        if (out_pushes != 3 || dut.state !== RUN) begin
            n_fail++;
            $display("FAIL rstmid_setup: pushes=%0d state=%0d want 3/RUN", out_pushes, dut.state);
        end
        rst = 1'b1;
        cycle();
        n_checks++;
        if (dut.state !== IDLE || bus.cpu_input_pc_valid !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_abort: state=%0d vld=%b done=%b want IDLE/0/0",
                     dut.state, bus.cpu_input_pc_valid, bus.done);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.start_ready !== 1'b1 || done_cnt != 0) begin
            n_fail++;
            $display("FAIL rstmid_idle: ready=%b dones=%0d want 1/0", bus.start_ready, done_cnt);
        end
        clear_model();
        add_char(8'h7a, 1'b1);
        run_to_done(8'h07, 40);
        n_checks++;
        if (issued_pc.size() != 1 || issued_pc[0] !== 8'h07 || done_acc !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_restart: n=%0d pc=%h acc=%b want 1/07/0", issued_pc.size(),
                     issued_pc.size() ? issued_pc[0] : 8'hxx, done_acc);
        end
    endtask

    initial begin
        test_reset();
        test_no_match();
        test_accept_next();
        test_same_char();
        test_nxt_full();
        test_flush();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
